// File: rtl/bias_relu_quant.sv
// Post-processing stage ahead of max-pool: psum + per-channel bias, rounding
// arithmetic right shift, optional ReLU and int8 saturation. Reads config,
// bias and psum SRAMs and writes one int8 activation per output word.
module bias_relu_quant #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  output logic              param_cs,
  output logic [ADDR_W-1:0] param_addr,
  input  logic [DATA_W-1:0] param_rdata,
  output logic              bias_cs,
  output logic [ADDR_W-1:0] bias_addr,
  input  logic [DATA_W-1:0] bias_rdata,
  output logic              psum_cs,
  output logic [ADDR_W-1:0] psum_addr,
  input  logic [DATA_W-1:0] psum_rdata,
  output logic              out_cs,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_PARAM = 3'd1;
  localparam logic [2:0] S_LOAD_BIAS  = 3'd2;
  localparam logic [2:0] S_PROCESS    = 3'd3;
  localparam logic [2:0] S_DRAIN      = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  // Two guard bits: one for the psum+bias carry, one for the rounding add.
  localparam int SW = DATA_W + 2;
  localparam logic signed [SW-1:0] SAT_HI = SW'(127);
  localparam logic signed [SW-1:0] SAT_LO = -SW'(128);

  logic [2:0]        state_reg;
  logic [2:0]        phase_cnt_reg;
  logic [15:0]       pix_cnt_reg;
  logic [9:0]        ch_reg;
  logic [ADDR_W-1:0] lin_addr_reg;
  logic [15:0]       num_pixel_reg;
  logic [9:0]        num_channel_reg;
  logic [4:0]        shift_reg;
  logic              relu_en_reg;
  logic [DATA_W-1:0] bias_reg;
  logic              rd_valid_reg;
  logic [ADDR_W-1:0] rd_addr_reg;

  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] rnd_c;
  logic signed [SW-1:0] shf_c;
  logic [7:0]           q_c;

  // Only the low bits of each config word carry meaning.
  logic unused_param_bits;
  assign unused_param_bits = ^param_rdata[DATA_W-1:16];

  // Datapath: bias add, round-half-up shift, ReLU, saturate to int8.
  always_comb begin
    sum_c = SW'($signed(psum_rdata)) + SW'($signed(bias_reg));
    rnd_c = sum_c;
    if (shift_reg != 5'd0) begin
      rnd_c = sum_c + (SW'(1) <<< (shift_reg - 5'd1));
    end
    shf_c = rnd_c >>> shift_reg;
    if (relu_en_reg && shf_c[SW-1]) begin
      shf_c = '0;
    end
    if (shf_c > SAT_HI) begin
      q_c = 8'h7F;
    end else if (shf_c < SAT_LO) begin
      q_c = 8'h80;
    end else begin
      q_c = shf_c[7:0];
    end
  end

  // Read-data stage and write stage: a result lands 2 cycles after its read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      out_cs       <= 1'b0;
      out_we       <= 1'b0;
      out_addr     <= '0;
      out_wdata    <= '0;
    end else begin
      rd_valid_reg <= psum_cs;
      rd_addr_reg  <= psum_addr;
      out_cs       <= rd_valid_reg;
      out_we       <= rd_valid_reg;
      if (rd_valid_reg) begin
        out_addr  <= rd_addr_reg;
        out_wdata <= {{(DATA_W-8){1'b0}}, q_c};
      end
    end
  end

  // Control FSM: config load, per-channel bias load, pixel issue and drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      phase_cnt_reg   <= '0;
      pix_cnt_reg     <= '0;
      ch_reg          <= '0;
      lin_addr_reg    <= '0;
      num_pixel_reg   <= '0;
      num_channel_reg <= '0;
      shift_reg       <= '0;
      relu_en_reg     <= 1'b0;
      bias_reg        <= '0;
      finish          <= 1'b0;
      param_cs        <= 1'b0;
      param_addr      <= '0;
      bias_cs         <= 1'b0;
      bias_addr       <= '0;
      psum_cs         <= 1'b0;
      psum_addr       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_LOAD_PARAM;
            phase_cnt_reg <= '0;
            ch_reg        <= '0;
            lin_addr_reg  <= '0;
            param_cs      <= 1'b1;
            param_addr    <= '0;
          end
        end

        S_LOAD_PARAM: begin
          phase_cnt_reg <= phase_cnt_reg + 3'd1;
          if (phase_cnt_reg < 3'd3) begin
            param_addr <= {{(ADDR_W-3){1'b0}}, phase_cnt_reg + 3'd1};
          end else begin
            param_cs <= 1'b0;
          end
          case (phase_cnt_reg)
            3'd1:    num_pixel_reg   <= param_rdata[15:0];
            3'd2:    num_channel_reg <= param_rdata[9:0];
            3'd3:    shift_reg       <= param_rdata[4:0];
            3'd4:    relu_en_reg     <= param_rdata[0];
            default: ;
          endcase
          if (phase_cnt_reg == 3'd4) begin
            if (num_pixel_reg == 16'd0 || num_channel_reg == 10'd0) begin
              state_reg <= S_DONE;
              finish    <= 1'b1;
            end else begin
              state_reg     <= S_LOAD_BIAS;
              phase_cnt_reg <= '0;
              bias_cs       <= 1'b1;
              bias_addr     <= '0;
            end
          end
        end

        S_LOAD_BIAS: begin
          phase_cnt_reg <= phase_cnt_reg + 3'd1;
          if (phase_cnt_reg == 3'd0) begin
            bias_cs <= 1'b0;
          end else begin
            bias_reg     <= bias_rdata;
            state_reg    <= S_PROCESS;
            pix_cnt_reg  <= '0;
            psum_cs      <= 1'b1;
            psum_addr    <= lin_addr_reg;
            lin_addr_reg <= lin_addr_reg + ADDR_W'(1);
          end
        end

        S_PROCESS: begin
          if (pix_cnt_reg == num_pixel_reg - 16'd1) begin
            psum_cs       <= 1'b0;
            state_reg     <= S_DRAIN;
            phase_cnt_reg <= '0;
          end else begin
            pix_cnt_reg  <= pix_cnt_reg + 16'd1;
            psum_addr    <= lin_addr_reg;
            lin_addr_reg <= lin_addr_reg + ADDR_W'(1);
          end
        end

        S_DRAIN: begin
          phase_cnt_reg <= phase_cnt_reg + 3'd1;
          if (phase_cnt_reg == 3'd1) begin
            if (ch_reg == num_channel_reg - 10'd1) begin
              state_reg <= S_DONE;
              finish    <= 1'b1;
            end else begin
              ch_reg        <= ch_reg + 10'd1;
              state_reg     <= S_LOAD_BIAS;
              phase_cnt_reg <= '0;
              bias_cs       <= 1'b1;
              bias_addr     <= {{(ADDR_W-10){1'b0}}, ch_reg + 10'd1};
            end
          end
        end

        S_DONE: begin
          if (!start) begin
            state_reg <= S_IDLE;
            finish    <= 1'b0;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          finish    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bias_relu_quant.md
Name: bias_relu_quant

Overview:
Post-processing stage directly upstream of the EPU max-pool stage. Reads 32-bit convolution partial sums from the psum SRAM and adds a per-channel bias. Applies a rounding arithmetic right shift, optional ReLU and int8 saturation, then writes one int8 activation per word into the activation SRAM that the max-pool stage consumes. Operation is start/finish handshaked and configured from the param SRAM.

Parameters:
ADDR_W, 32, width of all SRAM address ports
DATA_W, 32, width of all SRAM data ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  level; begins a run when sampled high in IDLE
finish  out  1  high while in DONE
param_cs  out  1  param SRAM chip select (read-only)
param_addr  out  ADDR_W  param SRAM word address
param_rdata  in  DATA_W  param SRAM read data, valid 1 cycle after cs+addr
bias_cs  out  1  bias SRAM chip select (read-only)
bias_addr  out  ADDR_W  bias word address = channel index
bias_rdata  in  DATA_W  signed 32-bit bias, 1-cycle read latency
psum_cs  out  1  psum SRAM chip select (read-only)
psum_addr  out  ADDR_W  psum word address, linear channel-major
psum_rdata  in  DATA_W  signed 32-bit partial sum, 1-cycle read latency
out_cs  out  1  activation SRAM chip select
out_we  out  1  activation SRAM write enable (1 = write)
out_addr  out  ADDR_W  activation word address, linear, same index as psum
out_wdata  out  DATA_W  {24'h0, int8 result}

Behaviour:
- Reset (rst high at clk edge): state=IDLE. All outputs 0: finish, every cs, out_we, every addr, out_wdata. Internal counters and config registers 0. Reset mid-run aborts with no further writes.
- Param words: 0=num_pixel (pixels per channel, [15:0] used), 1=num_channel ([9:0]), 2=shift ([4:0]), 3=relu_en ([0]).
- IDLE: start=1 -> LOAD_PARAM.
- LOAD_PARAM: param_cs=1; param_addr steps 0..3 over 4 cycles; word k is captured the cycle after addr k. Lasts 5 cycles, then -> LOAD_BIAS. If num_pixel==0 or num_channel==0 -> DONE; no psum/out access.
- LOAD_BIAS: bias_cs=1, bias_addr=ch. Bias is captured next cycle; 2 cycles total, then -> PROCESS.
- PROCESS: psum_cs=1. psum_addr = ch*num_pixel+p issued each cycle, p=0..num_pixel-1. Read data arrives 1 cycle later; result is registered 1 cycle after that.
- Latency: out_we=1, out_cs=1 and out_addr=k exactly 2 cycles after psum_addr=k is issued. Throughput 1 result/cycle within a channel.
- After the last pixel is issued, the 2-cycle pipeline drains; then -> LOAD_BIAS for ch+1. After the last channel drains -> DONE. No write is dropped or duplicated at channel boundaries.
- Arithmetic:
  - s = sext33(psum) + sext33(bias), 33-bit signed, no overflow.
  - If shift>0: s += 1<<(shift-1) (round half up), then arithmetic >> shift.
  - If relu_en and s<0: s=0.
  - Saturate to [-128,127]; emit two's-complement byte.
- out_we is high only on valid result cycles; out_wdata holds its last value otherwise.
- DONE: finish=1, all cs=0. Returns to IDLE when start=0; stays in DONE while start=1. A start pulse during a run is ignored.
- Total writes per run = num_pixel*num_channel, addresses 0..N-1, strictly ascending.

Test Plan:
- num_pixel=4, num_channel=1, shift=0, relu_en=0, bias=10, psum={5,-20,117,200} -> out bytes {15,-10(0xF6),127,127}. First out_we exactly 2 cycles after psum_addr=0. finish rises after the 4th write.
- shift=4, relu_en=1, bias=0, psum={24,23,-40,2047} -> {2,1,0,127}. Checks rounding: 24+8>>4=2, 23+8>>4=1.
- num_pixel=3, num_channel=2, biases {0,100}, psum all 1, shift=0 -> out_addr 0..5, data {1,1,1,101,101,101}, no gaps or duplicates at the channel boundary.
- Extremes: psum=0x7FFFFFFF, bias=0x7FFFFFFF, shift=0 -> 127. psum=0x80000000, bias=0x80000000, relu_en=0 -> -128 (33-bit sum, no wrap).
- num_channel=0 -> DONE after LOAD_PARAM, zero psum/out accesses. Hold start=1 -> finish stays 1; drop start -> IDLE, finish=0.
- Assert rst in PROCESS mid-channel -> next edge all outputs 0, state IDLE. A new start runs a full correct pass from address 0.
